// File: rtl/jtcps1_gfx_req_if.sv
// Bus between the graphics request block, its four layer clients, the
// CPS-1 ROM mapper and the SDRAM graphics slot.
interface jtcps1_gfx_req_if;
  // Client side
  logic [3:0]  req;
  logic [19:0] obj_addr;
  logic [19:0] scr1_addr;
  logic [19:0] scr2_addr;
  logic [19:0] scr3_addr;
  logic [3:0]  ok;
  logic [31:0] data;
  // Mapper side
  logic        map_enable;
  logic [2:0]  map_layer;
  logic [9:0]  map_cin;
  logic [3:0]  map_offset;
  logic [3:0]  map_mask;
  logic        map_unmapped;
  // SDRAM side
  logic        rom_cs;
  logic [19:0] rom_addr;
  logic        rom_ok;
  logic [31:0] rom_data;

  // The request block itself
  modport master (
    input  req, obj_addr, scr1_addr, scr2_addr, scr3_addr,
    input  map_offset, map_mask, map_unmapped,
    input  rom_ok, rom_data,
    output ok, data,
    output map_enable, map_layer, map_cin,
    output rom_cs, rom_addr
  );

  // Clients, mapper and SDRAM as seen from outside
  modport slave (
    output req, obj_addr, scr1_addr, scr2_addr, scr3_addr,
    output map_offset, map_mask, map_unmapped,
    output rom_ok, rom_data,
    input  ok, data,
    input  map_enable, map_layer, map_cin,
    input  rom_cs, rom_addr
  );
endinterface

// File: rtl/jtcps1_gfx_req.sv
// CPS-1 graphics ROM request initiator: round-robin arbitration of the four
// tile clients, one mapper lookup per request, then a single SDRAM word fetch.
// Unmapped codes skip the ROM and return an all-transparent word.
module jtcps1_gfx_req (
  input  logic              clk,
  input  logic              rst,
  jtcps1_gfx_req_if.master  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAP  = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] ROM  = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic [1:0]  prio_q,     prio_d;     // client searched first
  logic [1:0]  winner_q,   winner_d;
  logic [19:0] addr_q,     addr_d;     // address latched at grant
  logic        guard_q,    guard_d;    // first rom_cs cycle: ignore rom_ok
  logic [3:0]  ok_q,       ok_d;
  logic [31:0] data_q,     data_d;
  logic        map_en_q,   map_en_d;
  logic [2:0]  layer_q,    layer_d;
  logic [9:0]  cin_q,      cin_d;
  logic        rom_cs_q,   rom_cs_d;
  logic [19:0] rom_addr_q, rom_addr_d;

  logic [3:0]  pending;
  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [19:0] grant_addr;

  // Round-robin pick: a client completing this cycle is not eligible.
  always_comb begin
    pending   = bus.req & ~ok_q;
    grant_vld = 1'b0;
    grant_idx = prio_q;
    // Walk from lowest to highest priority so the last hit wins.
    for (int i = 3; i >= 0; i--) begin
      if (pending[prio_q + 2'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = prio_q + 2'(i);
      end
    end
    case (grant_idx)
      2'd0:    grant_addr = bus.obj_addr;
      2'd1:    grant_addr = bus.scr1_addr;
      2'd2:    grant_addr = bus.scr2_addr;
      default: grant_addr = bus.scr3_addr;
    endcase
  end

  // Next-state logic for the request sequencer.
  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    prio_d     = prio_q;
    winner_d   = winner_q;
    addr_d     = addr_q;
    guard_d    = guard_q;
    ok_d       = 4'b0000;
    data_d     = data_q;
    map_en_d   = 1'b0;
    layer_d    = layer_q;
    cin_d      = cin_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          winner_d = grant_idx;
          addr_d   = grant_addr;
          map_en_d = 1'b1;
          layer_d  = {1'b0, grant_idx};
          cin_d    = grant_addr[19:10];
          state_d  = MAP;
        end
      end
      MAP: begin
        // Mapper registers its bank at the end of this cycle.
        state_d = CALC;
      end
      CALC: begin
        if (bus.map_unmapped) begin
          data_d  = 32'hFFFF_FFFF;
          ok_d    = 4'b0001 << winner_q;
          prio_d  = winner_q + 2'd1;
          state_d = IDLE;
        end else begin
          rom_addr_d = {(addr_q[19:16] & bus.map_mask) | bus.map_offset, addr_q[15:0]};
          rom_cs_d   = 1'b1;
          guard_d    = 1'b1;
          state_d    = ROM;
        end
      end
      default: begin  // ROM
        if (guard_q) begin
          // A rom_ok here may belong to the previous SDRAM access.
          guard_d = 1'b0;
        end else if (bus.rom_ok) begin
          data_d   = bus.rom_data;
          rom_cs_d = 1'b0;
          ok_d     = 4'b0001 << winner_q;
          prio_d   = winner_q + 2'd1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // State registers; reset abandons any in-flight fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 2'd0;
      winner_q   <= 2'd0;
      addr_q     <= 20'd0;
      guard_q    <= 1'b0;
      ok_q       <= 4'b0000;
      data_q     <= 32'd0;
      map_en_q   <= 1'b0;
      layer_q    <= 3'd0;
      cin_q      <= 10'd0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= 20'd0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q    <= state_d;
      prio_q     <= prio_d;
      winner_q   <= winner_d;
      addr_q     <= addr_d;
      guard_q    <= guard_d;
      ok_q       <= ok_d;
      data_q     <= data_d;
      map_en_q   <= map_en_d;
      layer_q    <= layer_d;
      cin_q      <= cin_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign bus.ok         = ok_q;
  assign bus.data       = data_q;
  assign bus.map_enable = map_en_q;
  assign bus.map_layer  = layer_q;
  assign bus.map_cin    = cin_q;
  assign bus.rom_cs     = rom_cs_q;
  assign bus.rom_addr   = rom_addr_q;

endmodule

// File: tb/tb_jtcps1_gfx_req.sv
// Directed bench for jtcps1_gfx_req: vector table of single transactions,
// then reset-mid-fetch and round-robin sequences.
module tb_jtcps1_gfx_req;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jtcps1_gfx_req_if bus ();

  jtcps1_gfx_req dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // SDRAM model: rom_ok on rom_cs cycle (2 + rom_wait), or held high;
  // rom_data is garbage until that cycle.
  int          rom_wait = 0;
  logic        rom_hold = 1'b0;
  logic [31:0] rom_val  = 32'd0;
  int          cs_cnt   = 0;

  always @(negedge clk) begin
    if (bus.rom_cs) cs_cnt = cs_cnt + 1;
    else            cs_cnt = 0;
    bus.rom_ok   = rom_hold || (bus.rom_cs && cs_cnt == rom_wait + 2);
    bus.rom_data = (cs_cnt >= rom_wait + 2) ? rom_val : 32'h0BAD_0BAD;
  end

  typedef struct {
    logic [3:0]  req;     // served client
    logic [3:0]  bg;      // other clients requesting meanwhile
    logic [19:0] addr;
    logic [3:0]  off;
    logic [3:0]  msk;
    logic        unm;
    int          rwait;
    logic        hold;
    logic [31:0] rdata;
    logic [2:0]  layer;   // expected
    logic [9:0]  cin;
    logic [19:0] rom;
    logic [31:0] dexp;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_mapper(input logic [3:0] off, input logic [3:0] msk, input logic unm);
    bus.map_offset   = off;
    bus.map_mask     = msk;
    bus.map_unmapped = unm;
  endtask

  task automatic run_txn(input int k, input vec_t v);
    int   cyc;
    bit   got, cs_seen, cs_bad, extra;
    string p;
    p = $sformatf("v%0d_", k);
    set_mapper(v.off, v.msk, v.unm);
    rom_wait = v.rwait;
    rom_hold = v.hold;
    rom_val  = v.rdata;
    bus.obj_addr  = v.req[0] ? v.addr : ~v.addr;
    bus.scr1_addr = v.req[1] ? v.addr : ~v.addr;
    bus.scr2_addr = v.req[2] ? v.addr : ~v.addr;
    bus.scr3_addr = v.req[3] ? v.addr : ~v.addr;
    @(negedge clk);
    bus.req = v.req | v.bg;
    cyc = 0; got = 0; cs_seen = 0; cs_bad = 0; extra = 0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({p, "map_enable"}, 32'(bus.map_enable), 32'd1);
        check({p, "map_layer"},  32'(bus.map_layer),  32'(v.layer));
        check({p, "map_cin"},    32'(bus.map_cin),    32'(v.cin));
      end else if (bus.map_enable) begin
        extra = 1;
      end
      if (bus.rom_cs) begin
        cs_seen = 1;
        if (bus.rom_addr !== v.rom) cs_bad = 1;
      end else if (cs_seen && bus.ok == 4'd0) begin
        cs_bad = 1;
      end
      if (bus.ok != 4'd0) begin
        got = 1;
        check({p, "ok"},      32'(bus.ok), 32'(v.req));
        check({p, "data"},    bus.data,    v.dexp);
        check({p, "latency"}, cyc - 1,     v.lat);
      end
    end
    // Background clients give up before the next edge; the served one
    // keeps req through the edge where ok is sampled.
    bus.req = v.req;
    check({p, "completed"},     32'(got),     32'd1);
    check({p, "rom_cs_used"},   32'(cs_seen), 32'(!v.unm));
    check({p, "rom_cs_stable"}, 32'(cs_bad),  32'd0);
    check({p, "single_grant"},  32'(extra),   32'd0);
    @(posedge clk);
    #1 bus.req = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({p, "no_regrant"}, 32'(bus.map_enable), 32'd0);
      check({p, "ok_once"},    32'(bus.ok),         32'd0);
      check({p, "data_hold"},  bus.data,            v.dexp);
    end
  endtask

  // Present a set of requests; each client drops req on its own ok.
  // exp_order packs the served client indices, two bits each, first in [1:0].
  task automatic drain(input string tag, input logic [3:0] reqs,
                       input logic [7:0] exp_order, input int n_exp);
    logic [3:0] pend;
    logic [7:0] order;
    int         served, cyc;
    pend = reqs; order = 8'd0; served = 0; cyc = 0;
    @(negedge clk);
    bus.req = pend;
    while (pend != 4'd0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.ok != 4'd0) begin
        check({tag, "_ok_onehot"},  $countones(bus.ok),   32'd1);
        check({tag, "_ok_pending"}, 32'(bus.ok & ~pend),  32'd0);
        for (int i = 0; i < 4; i++)
          if (bus.ok[i] && served < 4) order[served*2 +: 2] = 2'(i);
        served++;
        pend = pend & ~bus.ok;
        @(posedge clk);
        #1 bus.req = pend;
      end
    end
    check({tag, "_served"}, served,     n_exp);
    check({tag, "_order"},  32'(order), 32'(exp_order));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        req      bg       addr       off   msk   unm rw  hold  rdata          layer cin      rom         dexp           lat
    vecs[0] = '{4'b0001, 4'b0000, 20'h3_1234, 4'h2, 4'h1, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, 3'd0, 10'h0C4, 20'h3_1234, 32'hDEAD_BEEF, 4};
    vecs[1] = '{4'b0100, 4'b0000, 20'hA_BCDE, 4'h0, 4'hF, 1'b1, 0, 1'b0, 32'h0,         3'd2, 10'h2AF, 20'h0_0000, 32'hFFFF_FFFF, 2};
    vecs[2] = '{4'b0010, 4'b0000, 20'hF_0001, 4'h0, 4'hF, 1'b0, 3, 1'b0, 32'h1234_5678, 3'd1, 10'h3C0, 20'hF_0001, 32'h1234_5678, 7};
    vecs[3] = '{4'b1000, 4'b0000, 20'h5_5AA5, 4'h8, 4'h0, 1'b0, 0, 1'b1, 32'hCAFE_F00D, 3'd3, 10'h156, 20'h8_5AA5, 32'hCAFE_F00D, 4};
    vecs[4] = '{4'b0001, 4'b1110, 20'h7_FFFF, 4'h1, 4'h6, 1'b0, 18, 1'b0, 32'hA5A5_5A5A, 3'd0, 10'h1FF, 20'h7_FFFF, 32'hA5A5_5A5A, 22};
    vecs[5] = '{4'b0001, 4'b0000, 20'h0_0400, 4'h3, 4'h3, 1'b1, 0, 1'b1, 32'h0,         3'd0, 10'h001, 20'h0_0000, 32'hFFFF_FFFF, 2};

    bus.req = 4'd0;
    bus.obj_addr = 20'd0; bus.scr1_addr = 20'd0; bus.scr2_addr = 20'd0; bus.scr3_addr = 20'd0;
    set_mapper(4'h0, 4'hF, 1'b0);

    // Power-on reset
    #1 rst = 1'b1;
    #3;
    check("rst_ok",         32'(bus.ok),         32'd0);
    check("rst_map_enable", 32'(bus.map_enable), 32'd0);
    check("rst_rom_cs",     32'(bus.rom_cs),     32'd0);
    check("rst_map_layer",  32'(bus.map_layer),  32'd0);
    check("rst_map_cin",    32'(bus.map_cin),    32'd0);
    check("rst_rom_addr",   32'(bus.rom_addr),   32'd0);
    check("rst_data",       bus.data,            32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_txn(k, vecs[k]);

    // Reset while the SDRAM fetch is outstanding
    set_mapper(4'h0, 4'hF, 1'b0);
    rom_wait = 10; rom_hold = 1'b0; rom_val = 32'h1111_2222;
    bus.scr1_addr = 20'h2_0000;
    @(negedge clk);
    bus.req = 4'b0010;
    begin
      int  cyc;
      bit  cs_up;
      cyc = 0; cs_up = 0;
      while (!cs_up && cyc < 20) begin
        @(negedge clk);
        cyc++;
        cs_up = bus.rom_cs;
      end
      check("midrst_cs_reached", 32'(cs_up), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_rom_cs",     32'(bus.rom_cs),     32'd0);
    check("midrst_ok",         32'(bus.ok),         32'd0);
    check("midrst_map_enable", 32'(bus.map_enable), 32'd0);
    check("midrst_rom_addr",   32'(bus.rom_addr),   32'd0);
    check("midrst_data",       bus.data,            32'd0);
    bus.req = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_abandoned", 32'(bus.ok | {3'd0, bus.rom_cs}), 32'd0);
    end

    // Round-robin with the pointer back at OBJ
    rom_wait = 0; rom_hold = 1'b1; rom_val = 32'h7777_8888;
    bus.obj_addr = 20'h1_0000; bus.scr1_addr = 20'h2_0400;
    bus.scr2_addr = 20'h3_0800; bus.scr3_addr = 20'h4_0C00;
    drain("rr_after_rst", 4'b0011, 8'h04, 2);
    drain("rr_scr3",      4'b1000, 8'h03, 1);
    check("rr_scr3_data", bus.data, 32'h7777_8888);
    drain("rr_all",       4'b1111, 8'hE4, 4);
    drain("rr_wrap",      4'b0011, 8'h04, 2);

    bus.req = 4'd0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
